// File: rtl/demoman_pkg.sv
// Shared constants for the demoman input path: button indices and frame timing.
package demoman_pkg;

  localparam int BTN_ATTACK = 1;
  localparam int BTN_RIGHT  = 2;
  localparam int BTN_LEFT   = 3;

  // First line of vertical blanking; its first appearance marks a new frame.
  localparam int TICK_LINE = 480;

  // 10 ms at the 25 MHz pixel clock.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
  localparam int CNT_W_DEFAULT           = 18;

endpackage

// File: rtl/input_conditioner_debouncer.sv
// One-button conditioner: 2-FF synchroniser, stability counter, debounced
// level and a one-cycle rise flag that is high in the first cycle of a press.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;
  logic             pressed;

  assign pressed = ~sync_2;

  // Synchronise the raw pin, then accept a new level only after it has
  // differed from the current one for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_1 <= key_n;
      sync_2 <= sync_1;
      rise   <= 1'b0;
      if (pressed != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= pressed;
          cnt    <= '0;
          rise   <= pressed;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Turns raw active-low keys into per-frame controls for player: debounced
// levels and latched press events, presented once per frame on frame_tick.
module input_conditioner
  import demoman_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT,
  parameter int TICK_LINE       = demoman_pkg::TICK_LINE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] key_n,
  input  logic [9:0]       pixel_y,
  output logic             frame_tick,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic             btn_any
);

  localparam logic [9:0] TICK_Y = 10'(TICK_LINE);

  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pending;
  logic [9:0]       prev_y;
  logic             tick_det;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_n[i]),
      .stable(stable[i]),
      .rise  (rise[i])
    );
  end

  // Only the first cycle on the tick line counts, so a held pixel_y fires once.
  assign tick_det = (pixel_y == TICK_Y) && (prev_y != TICK_Y);

  // Collect presses between ticks and publish a frame snapshot on each tick.
  // A rise landing on the tick cycle is reported now and not kept pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_y     <= TICK_Y;
      pending    <= '0;
      frame_tick <= 1'b0;
      btn_level  <= '0;
      btn_press  <= '0;
      btn_any    <= 1'b0;
    end else begin
      prev_y <= pixel_y;
      if (tick_det) begin
        btn_press  <= pending | rise;
        pending    <= '0;
        btn_level  <= stable;
        btn_any    <= |stable;
        frame_tick <= 1'b1;
      end else begin
        btn_press  <= '0;
        pending    <= pending | rise;
        frame_tick <= 1'b0;
      end
    end
  end

endmodule
